multi_conv_engine: RTL and testbench

MULTI_CONV_ENGINE -- requirements
Module: multi_conv_engine

---
 rtl/multi_conv_engine.sv | 172 +++++++++++++++++
 tb/tb_multi_conv_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_conv_engine.sv
// multi_conv_engine
//   Multi-channel FIR-style dot product engine. Every channel keeps a LEN-deep
//   shift window of samples. All channels share one LEN-tap kernel. Each
//   accepted input pushes one new sample per channel. The engine then spends
//   LEN cycles accumulating sum_k win_c[k] * kernel[k] for all channels in
//   parallel, and presents the per-channel results with a valid/ready handshake.
//
// Ports
//   clk          : clock, all logic on its rising edge
//   rst          : synchronous active-high reset
//   in_data      : CH samples, channel c at [c*DATA_W +: DATA_W]
//   kernel       : LEN taps, tap k at [k*DATA_W +: DATA_W] (latched on accept)
//   signed_mode  : 1 = two's-complement, 0 = unsigned (latched on accept)
//   win_clr      : zero all channel windows (only honoured in IDLE)
//   in_valid     : input handshake valid
//   in_ready     : input handshake ready (high only in IDLE and out of reset)
//   result       : CH results, channel c at [c*RES_W +: RES_W]
//   out_valid    : result valid, held until out_ready
//   out_ready    : output handshake ready
module multi_conv_engine #(
  parameter int DATA_W = 16,
  parameter int LEN    = 4,
  parameter int CH     = 2,
  parameter int RES_W  = 2*DATA_W + $clog2(LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*DATA_W-1:0]  in_data,
  input  logic [LEN*DATA_W-1:0] kernel,
  input  logic                  signed_mode,
  input  logic                  win_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CH*RES_W-1:0]   result,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int TAP_W  = $clog2(LEN);
  // Product of two (DATA_W+1)-bit extended operands. The multiply is done
  // at the wider of this and RES_W, so the low RES_W bits are exact for both
  // signed and unsigned operands.
  localparam int PROD_W = 2*DATA_W + 2;
  localparam int EXT_W  = (RES_W > PROD_W) ? RES_W : PROD_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic [LEN*DATA_W-1:0] kern_q, kern_d;
  logic                  sm_q, sm_d;
  logic [DATA_W-1:0]     win_q [CH][LEN];
  logic [DATA_W-1:0]     win_d [CH][LEN];
  logic [RES_W-1:0]      acc_q [CH];
  logic [RES_W-1:0]      acc_d [CH];
  logic [CH*RES_W-1:0]   result_q, result_d;

  logic                  last_tap;
  logic [DATA_W-1:0]     tap_coef;
  logic [EXT_W-1:0]      prod_full [CH];

  // Sign- or zero-extend one operand to the multiply width.
  function automatic logic [EXT_W-1:0] ext(input logic [DATA_W-1:0] v,
                                           input logic s);
    return {{(EXT_W-DATA_W){s & v[DATA_W-1]}}, v};
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  assign last_tap = (tap_q == TAP_W'(LEN-1));
  assign tap_coef = kern_q[int'(tap_q)*DATA_W +: DATA_W];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      prod_full[c] = ext(win_q[c][tap_q], sm_q) * ext(tap_coef, sm_q);
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    kern_d   = kern_q;
    sm_d     = sm_q;
    win_d    = win_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A simultaneous clear zeroes the old contents before the shift,
          // leaving only the new sample in the window.
          for (int c = 0; c < CH; c++) begin
            win_d[c][0] = in_data[c*DATA_W +: DATA_W];
            for (int k = 1; k < LEN; k++) begin
              win_d[c][k] = win_clr ? '0 : win_q[c][k-1];
            end
            acc_d[c] = '0;
          end
          kern_d  = kernel;
          sm_d    = signed_mode;
          tap_d   = '0;
          state_d = CALC;
        end else if (win_clr) begin
          for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < LEN; k++) begin
              win_d[c][k] = '0;
            end
          end
        end
      end

      CALC: begin
        for (int c = 0; c < CH; c++) begin
          acc_d[c] = acc_q[c] + prod_full[c][RES_W-1:0];
        end
        if (last_tap) begin
          // The final product is folded straight into the registered result.
          for (int c = 0; c < CH; c++) begin
            result_d[c*RES_W +: RES_W] = acc_d[c];
          end
          tap_d   = '0;
          state_d = DONE;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the windows and accumulators are storage arrays, but they are
  // reset anyway: a reset must leave empty windows so the next result does
  // not depend on samples from before the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tap_q    <= '0;
      kern_q   <= '0;
      sm_q     <= 1'b0;
      result_q <= '0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c] <= '0;
        for (int k = 0; k < LEN; k++) begin
          win_q[c][k] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      kern_q   <= kern_d;
      sm_q     <= sm_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      win_q    <= win_d;
    end
  end

endmodule

// File: tb/tb_multi_conv_engine.sv
// tb_multi_conv_engine
//   Directed bench for multi_conv_engine at DATA_W=16, LEN=4, CH=2.
//   Each scenario task drives stimulus and compares against hand-computed
//   values. Outputs are sampled 1 time unit after the rising edge.
module tb_multi_conv_engine;

  localparam int DATA_W = 16;
  localparam int LEN    = 4;
  localparam int CH     = 2;
  localparam int RES_W  = 34;

  logic                  clk;
  logic                  rst;
  logic [CH*DATA_W-1:0]  in_data;
  logic [LEN*DATA_W-1:0] kernel;
  logic                  signed_mode;
  logic                  win_clr;
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*RES_W-1:0]   result;
  logic                  out_valid;
  logic                  out_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [LEN*DATA_W-1:0] KERN_1234 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [LEN*DATA_W-1:0] KERN_FFFF = {4{16'hFFFF}};

  multi_conv_engine #(
    .DATA_W(DATA_W), .LEN(LEN), .CH(CH), .RES_W(RES_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .kernel     (kernel),
    .signed_mode(signed_mode),
    .win_clr    (win_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accept one sample pair, then wait (bounded) for out_valid. lat is the
  // number of edges from the accept edge to out_valid (99 on timeout); res is
  // the result seen with out_valid. One more edge follows, so with
  // out_ready=1 the engine is back in IDLE on return.
  task automatic send(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1,
                      input logic [LEN*DATA_W-1:0] kern, input logic sm,
                      input logic clr, output int lat,
                      output logic [CH*RES_W-1:0] res);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    in_data     = {s1, s0};
    kernel      = kern;
    signed_mode = sm;
    win_clr     = clr;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    win_clr  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = 99;
    res = result;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b result=%h want 0/0", out_valid, result);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    logic [RES_W-1:0] exp0 [4];
    int lat;
    logic [CH*RES_W-1:0] res;
    exp0[0] = 34'd1;  exp0[1] = 34'd4;  exp0[2] = 34'd10; exp0[3] = 34'd20;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(DATA_W'(i + 1), 16'd0, KERN_1234, 1'b0, 1'b0, lat, res);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL unsigned_latency[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if (res[0 +: RES_W] !== exp0[i] || res[RES_W +: RES_W] !== '0) begin
        errors++;
        $display("FAIL unsigned_result[%0d]: ch0=%0d ch1=%0d want %0d/0",
                 i, res[0 +: RES_W], res[RES_W +: RES_W], exp0[i]);
      end
    end
  endtask

  task automatic test_sign_ext();
    int lat;
    logic [CH*RES_W-1:0] res;
    do_reset();
    send(16'hFFFF, 16'h0000, KERN_FFFF, 1'b1, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd1 || res[RES_W +: RES_W] !== '0) begin
      errors++;
      $display("FAIL signed_m1xm1: ch0=%h ch1=%h want 000000001/0",
               res[0 +: RES_W], res[RES_W +: RES_W]);
    end
    do_reset();
    send(16'hFFFF, 16'h0000, KERN_FFFF, 1'b0, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'h0FFFE0001) begin
      errors++;
      $display("FAIL unsigned_max_single: ch0=%h want 0fffe0001", res[0 +: RES_W]);
    end
  endtask

  task automatic test_full_width();
    int lat;
    logic [CH*RES_W-1:0] res;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(16'hFFFF, 16'hFFFF, KERN_FFFF, 1'b0, 1'b0, lat, res);
    end
    checks++;
    if (res[0 +: RES_W] !== 34'h3FFF80004 || res[RES_W +: RES_W] !== 34'h3FFF80004) begin
      errors++;
      $display("FAIL full_width: ch0=%h ch1=%h want 3fff80004 both",
               res[0 +: RES_W], res[RES_W +: RES_W]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    logic [CH*RES_W-1:0] res;
    do_reset();
    out_ready = 1'b0;
    send(16'd7, 16'd0, KERN_1234, 1'b0, 1'b0, lat, res);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = {16'd100, 16'd100};
      win_clr  = 1'b1;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result[0 +: RES_W] !== 34'd7) bad++;
    end
    in_valid = 1'b0;
    win_clr  = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles, last out_valid=%b in_ready=%b ch0=%0d want 1/0/7",
               bad, out_valid, in_ready, result[0 +: RES_W]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result[0 +: RES_W] !== 34'd7) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b ch0=%0d want 0/1/7",
               out_valid, in_ready, result[0 +: RES_W]);
    end
    // The stalled pulses must not have touched the window: [0,7,0,0] -> 7*2.
    send(16'd0, 16'd0, KERN_1234, 1'b0, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd14) begin
      errors++;
      $display("FAIL stall_ignored_inputs: ch0=%0d want 14", res[0 +: RES_W]);
    end
  endtask

  task automatic test_win_clr();
    int lat;
    logic [CH*RES_W-1:0] res;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(DATA_W'(i + 1), DATA_W'(10 * (i + 1)), KERN_1234, 1'b0, 1'b0, lat, res);
    end
    send(16'd5, 16'd6, KERN_1234, 1'b0, 1'b1, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd5 || res[RES_W +: RES_W] !== 34'd6 || lat !== 4) begin
      errors++;
      $display("FAIL clr_with_valid: ch0=%0d ch1=%0d lat=%0d want 5/6/4",
               res[0 +: RES_W], res[RES_W +: RES_W], lat);
    end
    // Clear alone while idle, then a single sample: window [9,0,0,0].
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    send(16'd9, 16'd2, KERN_1234, 1'b0, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd9 || res[RES_W +: RES_W] !== 34'd2) begin
      errors++;
      $display("FAIL clr_idle: ch0=%0d ch1=%0d want 9/2",
               res[0 +: RES_W], res[RES_W +: RES_W]);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int seen;
    logic [CH*RES_W-1:0] res;
    do_reset();
    send(16'd3, 16'd1, KERN_1234, 1'b0, 1'b0, lat, res);
    in_data     = {16'd1, 16'd3};
    kernel      = KERN_1234;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    tick();              // accept edge T
    in_valid = 1'b0;
    tick();              // edge T+1, now in the 2nd CALC cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc: out_valid cycles=%0d result=%h want 0/0", seen, result);
    end
    send(16'd3, 16'd1, KERN_1234, 1'b0, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd3 || res[RES_W +: RES_W] !== 34'd1 || lat !== 4) begin
      errors++;
      $display("FAIL post_reset_run: ch0=%0d ch1=%0d lat=%0d want 3/1/4",
               res[0 +: RES_W], res[RES_W +: RES_W], lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic [CH*RES_W-1:0] res;
    do_reset();
    send(16'd2, 16'd0, KERN_1234, 1'b0, 1'b0, lat, res);
    // send() consumed the handshake edge; in_ready must already be high.
    gap = 0;
    while (!in_ready && gap < 10) begin
      tick();
      gap++;
    end
    checks++;
    if (gap != 0) begin
      errors++;
      $display("FAIL back_to_back_ready: extra idle cycles=%0d want 0", gap);
    end
    send(16'd1, 16'd0, KERN_1234, 1'b1, 1'b0, lat, res);
    checks++;
    if (res[0 +: RES_W] !== 34'd5) begin
      errors++;
      $display("FAIL back_to_back_result: ch0=%0d want 5", res[0 +: RES_W]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    kernel      = '0;
    signed_mode = 1'b0;
    win_clr     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;

    test_reset();
    test_unsigned();
    test_sign_ext();
    test_full_width();
    test_backpressure();
    test_win_clr();
    test_reset_mid_calc();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
